// File: rtl/spi_master_counter_tx_if.sv
// spi_master_counter_tx_if: request/status and SPI pin bundle between the counter SPI master and its user/slave side
interface spi_master_counter_tx_if;
  logic        start;
  logic [13:0] tx_data;
  logic        busy;
  logic        done;
  logic [15:0] rx_data;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic        n_SS;
  modport master (input start, tx_data, MISO, output busy, done, rx_data, SCLK, MOSI, n_SS);
  modport slave (output start, tx_data, MISO, input busy, done, rx_data, SCLK, MOSI, n_SS);
endinterface

// File: rtl/spi_master_counter_tx.sv
// spi_master_counter_tx: sends a 14-bit counter as one 16-bit mode-0 SPI frame, MSB first
module spi_master_counter_tx #(
  parameter int CLK_DIV = 50
) (
  input logic clk,
  input logic reset,
  spi_master_counter_tx_if.master bus
);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
  typedef enum logic [1:0] {IDLE, SETUP, SCLK_HI, SCLK_LO} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0] bit_q, bit_d;
  logic [15:0] shift_q, shift_d, rx_q, rx_d, rxo_q, rxo_d;
  logic sclk_q, sclk_d, mosi_q, mosi_d, nss_q, nss_d, busy_q, busy_d, done_q, done_d;
  logic wrap;
  assign wrap = div_q == LAST;
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    shift_d = shift_q;
    rx_d = rx_q;
    rxo_d = rxo_q;
    sclk_d = sclk_q;
    mosi_d = mosi_q;
    nss_d = nss_q;
    busy_d = busy_q;
    done_d = 1'b0;
    div_d = (state_q == IDLE || wrap) ? '0 : div_q + DW'(1);
    case (state_q)
      SETUP: if (wrap) begin
        state_d = SCLK_HI;
        sclk_d = 1'b1;
        rx_d = {rx_q[14:0], bus.MISO};
      end
      SCLK_HI: if (wrap) begin
        state_d = SCLK_LO;
        sclk_d = 1'b0;
        shift_d = shift_q << 1;
        mosi_d = shift_q[14];
      end
      SCLK_LO: if (wrap) begin
        state_d = (bit_q == 4'd15) ? IDLE : SCLK_HI;
        bit_d = (bit_q == 4'd15) ? bit_q : bit_q + 4'd1;
        sclk_d = bit_q != 4'd15;
        rx_d = (bit_q == 4'd15) ? rx_q : {rx_q[14:0], bus.MISO};
        nss_d = bit_q == 4'd15;
        busy_d = bit_q != 4'd15;
        done_d = bit_q == 4'd15;
        rxo_d = (bit_q == 4'd15) ? rx_q : rxo_q;
      end
      default: if (bus.start) begin
        state_d = SETUP;
        shift_d = {2'b00, bus.tx_data};
        mosi_d = 1'b0;
        bit_d = 4'd0;
        rx_d = '0;
        nss_d = 1'b0;
        busy_d = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      div_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      rx_q <= '0;
      rxo_q <= '0;
      sclk_q <= 1'b0;
      mosi_q <= 1'b0;
      nss_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      rx_q <= rx_d;
      rxo_q <= rxo_d;
      sclk_q <= sclk_d;
      mosi_q <= mosi_d;
      nss_q <= nss_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign bus.SCLK = sclk_q;
  assign bus.MOSI = mosi_q;
  assign bus.n_SS = nss_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.rx_data = rxo_q;
endmodule

// File: tb/tb_spi_master_counter_tx.sv
// tb_spi_master_counter_tx: directed frames against a mode-0 slave model with MISO looped back to MOSI
module tb_spi_master_counter_tx;
  localparam int CLK_DIV = 4;
  localparam int LAT = 1 + 33 * CLK_DIV;
  logic clk = 1'b0;
  logic reset;
  spi_master_counter_tx_if bus();
  spi_master_counter_tx #(.CLK_DIV(CLK_DIV)) dut (.clk(clk), .reset(reset), .bus(bus));
  assign bus.MISO = bus.MOSI;
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] sr = '0, last_rx = '0;
  int bits = 0, edges = 0, frames = 0, glitches = 0;
  logic sclk_prev = 1'b0, mosi_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.n_SS) bits <= 0;
    else if (bus.SCLK && !sclk_prev) begin
      sr <= {sr[14:0], bus.MOSI};
      bits <= bits + 1;
      edges <= edges + 1;
      if (bits == 15) begin
        last_rx <= {sr[14:0], bus.MOSI};
        frames <= frames + 1;
      end
    end
    if (!bus.n_SS && bus.SCLK && sclk_prev && bus.MOSI != mosi_prev) glitches <= glitches + 1;
    sclk_prev <= bus.SCLK;
    mosi_prev <= bus.MOSI;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic accept(input logic [13:0] d);
    bus.start = 1'b1;
    bus.tx_data = d;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  task automatic wait_done(input int c0, output int cyc, output int first_hi);
    cyc = c0;
    first_hi = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus.SCLK && first_hi == 0) first_hi = cyc;
    end while (!bus.done && cyc < 400);
  endtask
  task automatic run_frame(input logic [13:0] d, input logic [7:0] b0, input logic [7:0] b1);
    int cyc, fh, e0, f0;
    @(negedge clk);
    e0 = edges;
    f0 = frames;
    accept(d);
    wait_done(0, cyc, fh);
    check("done_latency", cyc, LAT);
    check("first_sclk_rise", fh, 1 + CLK_DIV);
    check("busy_at_done", bus.busy, 0);
    check("nss_at_done", bus.n_SS, 1);
    check("rx_data_loopback", bus.rx_data, {b0, b1});
    @(negedge clk);
    check("done_one_cycle", bus.done, 0);
    check("rising_edges", edges - e0, 16);
    check("frames_received", frames - f0, 1);
    check("slave_byte0", last_rx[15:8], b0);
    check("slave_byte1", last_rx[7:0], b1);
  endtask
  typedef struct {
    logic [13:0] d;
    logic [7:0] b0;
    logic [7:0] b1;
  } vec_t;
  vec_t vecs[4];
  initial begin
    int cyc, fh, e0, f0, seen;
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int cyc, fh, e0, f0, seen;
    vecs[0] = '{14'h2A5C, 8'h2A, 8'h5C};
    vecs[1] = '{14'h3FFF, 8'h3F, 8'hFF};
    vecs[2] = '{14'h0000, 8'h00, 8'h00};
    vecs[3] = '{14'h1A5A, 8'h1A, 8'h5A};
    reset = 1'b1;
    bus.start = 1'b1;
    bus.tx_data = 14'h3FFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sclk", bus.SCLK, 0);
    check("rst_mosi", bus.MOSI, 0);
    check("rst_nss", bus.n_SS, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rx_data", bus.rx_data, 0);
    reset = 1'b0;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("no_frame_after_rst", {bus.busy, bus.n_SS}, 2'b01);
    foreach (vecs[i]) run_frame(vecs[i].d, vecs[i].b0, vecs[i].b1);
    // start mid-frame must be dropped, then a start in the done cycle must be taken
    @(negedge clk);
    f0 = frames;
    accept(14'h0001);
    repeat (40) @(negedge clk);
    bus.start = 1'b1;
    bus.tx_data = 14'h1234;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(41, cyc, fh);
    check("busy_ignore_latency", cyc, LAT);
    check("busy_ignore_word", last_rx, 16'h0001);
    accept(14'h0002);
    @(negedge clk);
    check("b2b_nss_gap", bus.n_SS, 0);
    check("b2b_busy", bus.busy, 1);
    wait_done(1, cyc, fh);
    check("b2b_latency", cyc, LAT);
    check("b2b_rx_data", bus.rx_data, 16'h0002);
    @(negedge clk);
    check("b2b_word", last_rx, 16'h0002);
    check("b2b_frames", frames - f0, 2);
    // abort after the seventh rising edge
    e0 = edges;
    f0 = frames;
    accept(14'h2AAA);
    cyc = 0;
    while (edges - e0 < 7 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_reached_7_edges", edges - e0, 7);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_nss", bus.n_SS, 1);
    check("abort_sclk", bus.SCLK, 0);
    check("abort_busy", bus.busy, 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check("abort_no_done", seen, 0);
    check("abort_no_frame", frames - f0, 0);
    run_frame(14'h0155, 8'h01, 8'h55);
    check("mosi_stable_while_sclk_hi", glitches, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
